heading_pid: RTL

Closed-loop heading controller that produces the signed left/right wheel speed commands consumed by the motor-drive stage. It takes a signed heading error from the heading/sensor-fusion path together with a forward speed request. It computes a saturating P + I + D correction over a short register pipeline, then outputs `frwrd ± correction` on each side, saturated to the 11-bit signed range the motor driver expects.

---
 rtl/heading_ctrl_pkg.sv | 21 ++
 rtl/heading_pid_signed_sat.sv | 14 +
 rtl/heading_pid.sv | 112 +++++++++++
 3 files changed

// File: rtl/heading_ctrl_pkg.sv
// heading_ctrl_pkg: widths, saturation limits and speed type shared by heading control and motor drive
package heading_ctrl_pkg;
    localparam int ERR_W     = 12;
    localparam int ERR_SAT_W = 10;
    localparam int INTEG_W   = 15;
    localparam int SPD_W     = 11;
    localparam int FRWRD_W   = 10;
    localparam int DIFF_W    = 7;
    localparam int P_W       = 14;
    localparam int I_W       = 9;
    localparam int D_W       = 12;
    localparam int SUM_W     = 15;
    localparam int CORR_W    = 12;
    localparam int ERR_SAT_MAX = 511;
    localparam int ERR_SAT_MIN = -512;
    localparam int DIFF_MAX    = 63;
    localparam int DIFF_MIN    = -64;
    localparam int SPD_MAX     = 1023;
    localparam int SPD_MIN     = -1024;
    typedef logic signed [SPD_W-1:0] spd_t;
endpackage

// File: rtl/heading_pid_signed_sat.sv
// signed_sat: combinational clamp of a signed IN_W value into the signed OUT_W range
module signed_sat #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    logic ovf;
    // in range exactly when every bit above the output sign bit matches it
    assign ovf  = !((&din[IN_W-1:OUT_W-1]) || !(|din[IN_W-1:OUT_W-1]));
    assign dout = ovf ? (din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                      : din[OUT_W-1:0];
endmodule

// File: rtl/heading_pid.sv
// heading_pid: saturating P+I(+D) heading correction applied differentially to forward speed.
// HEADING_DTERM_EN builds the derivative history and D term; otherwise D contributes 0.
module heading_pid
    import heading_ctrl_pkg::*;
#(
    parameter int P_COEFF = 6,
    parameter int D_COEFF = 7,
    parameter int D_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [ERR_W-1:0]  error,
    input  logic                     err_vld,
    input  logic                     moving,
    input  logic [FRWRD_W-1:0]       frwrd,
    output spd_t                     lft_spd,
    output spd_t                     rght_spd
);
    // out-of-range gains would overflow the term widths, so such a build stays idle
    localparam bit cfg_ok = (P_COEFF >= 0) && (P_COEFF <= 15) && (D_COEFF >= 0) &&
                            (D_COEFF <= 31) && (D_DEPTH >= 1) && (D_DEPTH <= 4);

    logic signed [ERR_SAT_W-1:0] err_sat_c, err_sat;
    logic                        vld_a;
    logic signed [P_W-1:0]       p_nxt, p_q;
    logic signed [I_W-1:0]       i_q;
    logic signed [D_W-1:0]       d_q;
    logic signed [INTEG_W-1:0]   integ, integ_sum, integ_nxt;
    logic                        integ_ovf;
    logic signed [SUM_W-1:0]     sum;
    logic signed [CORR_W-1:0]    corr;
    logic signed [SPD_W+1:0]     l_raw, r_raw;
    spd_t                        l_sat, r_sat;

    signed_sat #(.IN_W(ERR_W), .OUT_W(ERR_SAT_W)) u_err_sat (.din(error), .dout(err_sat_c));

    always_ff @(posedge clk) begin
        if (rst || !moving) begin
            err_sat <= '0;
            vld_a   <= 1'b0;
        end else begin
            err_sat <= err_sat_c;
            vld_a   <= err_vld & cfg_ok;
        end
    end

    always_comb begin
        p_nxt     = P_W'(err_sat) * P_W'(P_COEFF);
        integ_sum = integ + INTEG_W'(err_sat);
        integ_ovf = (integ[INTEG_W-1] == err_sat[ERR_SAT_W-1]) &&
                    (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
        integ_nxt = (vld_a && !integ_ovf) ? integ_sum : integ;
    end

    // I_q samples the integrator including the sample being loaded
    always_ff @(posedge clk) begin
        if (rst || !moving) begin
            integ <= '0;
            p_q   <= '0;
            i_q   <= '0;
        end else begin
            integ <= integ_nxt;
            if (vld_a) begin
                p_q <= p_nxt;
                i_q <= integ_nxt[INTEG_W-1:INTEG_W-I_W];
            end
        end
    end

`ifdef HEADING_DTERM_EN
    logic signed [ERR_SAT_W-1:0] hist [D_DEPTH];
    logic signed [ERR_SAT_W:0]   diff_raw;
    logic signed [DIFF_W-1:0]    diff;
    logic signed [D_W-1:0]       d_nxt;

    assign diff_raw = {err_sat[ERR_SAT_W-1], err_sat} -
                      {hist[D_DEPTH-1][ERR_SAT_W-1], hist[D_DEPTH-1]};
    signed_sat #(.IN_W(ERR_SAT_W+1), .OUT_W(DIFF_W)) u_diff_sat (.din(diff_raw), .dout(diff));
    assign d_nxt = D_W'(diff) * D_W'(D_COEFF);

    always_ff @(posedge clk) begin
        if (rst || !moving) begin
            for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
            d_q <= '0;
        end else if (vld_a) begin
            hist[0] <= err_sat;
            for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
            d_q <= d_nxt;
        end
    end
`else
    assign d_q = '0;
`endif

    assign sum   = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(d_q);
    assign corr  = CORR_W'(sum >>> 3);
    assign l_raw = (SPD_W+2)'(frwrd) + (SPD_W+2)'(corr);
    assign r_raw = (SPD_W+2)'(frwrd) - (SPD_W+2)'(corr);

    signed_sat #(.IN_W(SPD_W+2), .OUT_W(SPD_W)) u_lft_sat  (.din(l_raw), .dout(l_sat));
    signed_sat #(.IN_W(SPD_W+2), .OUT_W(SPD_W)) u_rght_sat (.din(r_raw), .dout(r_sat));

    always_ff @(posedge clk) begin
        if (rst || !moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            lft_spd  <= l_sat;
            rght_spd <= r_sat;
        end
    end
endmodule
